// File: rtl/mod16_down_counter.sv
// Synchronous modulo-MODULUS down counter with parallel load, one-shot stop and
// a combinational borrow (tc) so stages cascade into wider counters and timers.
module mod16_down_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done,
    output logic             dbg_state
);

    // Handshake: none. en and load are level strobes sampled on each falling
    // edge of clk; priority is rst > load > en > hold. tc = en & (q == 0).

    typedef enum logic {
        COUNTING = 1'b0,
        EXPIRED  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_done;

    logic             w_zero;
    logic [WIDTH-1:0] w_load_val;

    assign w_zero     = (r_q == '0);
    // Out-of-range load values saturate so q never leaves 0..MODULUS-1.
    assign w_load_val = (d > MAX_COUNT) ? MAX_COUNT : d;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_q     <= MAX_COUNT;
            r_state <= COUNTING;
            r_done  <= 1'b0;
        end else if (load) begin
            r_q     <= w_load_val;
            r_state <= COUNTING;
            r_done  <= 1'b0;
        end else if (en) begin
            if (!w_zero) begin
                r_q <= r_q - ONE;
            end else if (oneshot) begin
                // Stop at zero; done stays set until the next load or reset.
                r_state <= EXPIRED;
                r_done  <= 1'b1;
            end else begin
                r_q <= MAX_COUNT;
            end
        end
    end

    assign q         = r_q;
    assign done      = r_done;
    assign tc        = en & w_zero;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mod16_down_counter.sv
// Directed bench for mod16_down_counter: vector table for the mod-16 instance,
// hand sequences for the mod-10 clamp and a two-stage cascade.
module tb_mod16_down_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, MODULUS = 16
    logic       rst, en, load, oneshot;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, done, dbg_state;

    mod16_down_counter #(.WIDTH(4), .MODULUS(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .oneshot(oneshot),
        .q(q), .tc(tc), .done(done), .dbg_state(dbg_state)
    );

    // MODULUS = 10 instance for clamping
    logic       t_rst, t_en, t_load, t_oneshot;
    logic [3:0] t_d;
    logic [3:0] t_q;
    logic       t_tc, t_done, t_dbg;

    mod16_down_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
        .clk(clk), .rst(t_rst), .en(t_en), .load(t_load), .d(t_d), .oneshot(t_oneshot),
        .q(t_q), .tc(t_tc), .done(t_done), .dbg_state(t_dbg)
    );

    // Two-stage cascade
    logic       c_rst;
    logic       c_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_done, hi_done, lo_dbg, hi_dbg;

    mod16_down_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .load(1'b0), .d(4'd0), .oneshot(1'b0),
        .q(lo_q), .tc(lo_tc), .done(lo_done), .dbg_state(lo_dbg)
    );

    mod16_down_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .load(1'b0), .d(4'd0), .oneshot(1'b0),
        .q(hi_q), .tc(hi_tc), .done(hi_done), .dbg_state(hi_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       load;
        logic       en;
        logic       oneshot;
        logic [3:0] d;
        logic       exp_tc;    // tc with these inputs, before the edge
        logic [3:0] exp_q;     // q after the edge
        logic       exp_done;  // done after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic l, input logic e, input logic os,
                                input logic [3:0] dv, input logic etc, input logic [3:0] eq,
                                input logic ed);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.oneshot = os; v.d = dv;
        v.exp_tc = etc; v.exp_q = eq; v.exp_done = ed;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; oneshot = 1'b0; d = 4'd0;
        t_rst = 1'b1; t_en = 1'b0; t_load = 1'b0; t_oneshot = 1'b0; t_d = 4'd0;
        c_rst = 1'b1; c_en = 1'b1;

        // Reset then a full wrapping count
        add(1, 0, 0, 0, 4'd0, 0, 4'd15, 0);
        for (int i = 0; i < 15; i++) add(0, 0, 1, 0, 4'd0, 0, 4'(14 - i), 0);
        add(0, 0, 1, 0, 4'd0, 1, 4'd15, 0);
        // One-shot from 5
        add(0, 1, 0, 1, 4'd5, 0, 4'd5, 0);
        add(0, 0, 1, 1, 4'd0, 0, 4'd4, 0);
        add(0, 0, 1, 1, 4'd0, 0, 4'd3, 0);
        add(0, 0, 1, 1, 4'd0, 0, 4'd2, 0);
        add(0, 0, 1, 1, 4'd0, 0, 4'd1, 0);
        add(0, 0, 1, 1, 4'd0, 0, 4'd0, 0);
        add(0, 0, 1, 1, 4'd0, 1, 4'd0, 1);
        add(0, 0, 1, 1, 4'd0, 1, 4'd0, 1);
        add(0, 0, 1, 1, 4'd0, 1, 4'd0, 1);
        // done is sticky across idle cycles and an oneshot change
        add(0, 0, 0, 0, 4'd0, 0, 4'd0, 1);
        add(0, 0, 0, 0, 4'd9, 0, 4'd0, 1);
        // Reset beats load and en; clears done
        add(1, 1, 1, 1, 4'd3, 1, 4'd15, 0);
        // Load beats en
        add(0, 1, 1, 0, 4'd7, 0, 4'd7, 0);
        // en pattern 1,0,0,1 from 4
        add(0, 1, 0, 0, 4'd4, 0, 4'd4, 0);
        add(0, 0, 1, 0, 4'd0, 0, 4'd3, 0);
        add(0, 0, 0, 0, 4'd0, 0, 4'd3, 0);
        add(0, 0, 0, 0, 4'd0, 0, 4'd3, 0);
        add(0, 0, 1, 0, 4'd0, 0, 4'd2, 0);
        // Load zero, then wrap; load clears done after a fresh expiry
        add(0, 1, 0, 0, 4'd0, 0, 4'd0, 0);
        add(0, 0, 1, 1, 4'd0, 1, 4'd0, 1);
        add(0, 1, 0, 0, 4'd0, 0, 4'd0, 0);
        add(0, 0, 1, 0, 4'd0, 1, 4'd15, 0);
        add(0, 1, 1, 1, 4'd15, 0, 4'd15, 0);

        @(negedge clk); #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; load = vecs[i].load; en = vecs[i].en;
            oneshot = vecs[i].oneshot; d = vecs[i].d;
            #1;
            chk($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].exp_tc));
            @(negedge clk); #1;
            chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
            chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].exp_done));
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;

        // MODULUS = 10: reset, clamp, wrap to 9
        @(negedge clk); #1;
        chk("m10_reset_q", int'(t_q), 9);
        t_rst = 1'b0; t_load = 1'b1; t_d = 4'd13;
        @(negedge clk); #1;
        chk("m10_clamp13_q", int'(t_q), 9);
        t_d = 4'd10;
        @(negedge clk); #1;
        chk("m10_clamp10_q", int'(t_q), 9);
        t_d = 4'd6;
        @(negedge clk); #1;
        chk("m10_load6_q", int'(t_q), 6);
        t_d = 4'd0;
        @(negedge clk); #1;
        chk("m10_load0_q", int'(t_q), 0);
        t_load = 1'b0; t_en = 1'b1; t_oneshot = 1'b0;
        #1;
        chk("m10_tc_at0", int'(t_tc), 1);
        @(negedge clk); #1;
        chk("m10_wrap_q", int'(t_q), 9);
        chk("m10_tc_at9", int'(t_tc), 0);
        @(negedge clk); #1;
        chk("m10_dec_q", int'(t_q), 8);
        t_en = 1'b0;

        // Cascade: 8-bit down count over 256 edges
        @(negedge clk); #1;
        chk("casc_reset", int'({hi_q, lo_q}), 255);
        c_rst = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            if (k == 256) begin
                chk("casc_lo_tc_at0", int'(lo_tc), 1);
                chk("casc_hi_tc_at0", int'(hi_tc), 1);
            end
            @(negedge clk); #1;
            chk($sformatf("casc_k%0d", k), int'({hi_q, lo_q}), (511 - k) % 256);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
